// File: rtl/axis_ctrlsrc_select_mc_if.sv
// rtl/axis_ctrlsrc_select_mc_if.sv - source/result stream bundle for the control-source selector
interface axis_ctrlsrc_select_mc_if #(
    parameter int SAXIS_DATA_WIDTH = 32,
    parameter int MAXIS_DATA_WIDTH = 32,
    parameter int N_SRC            = 4
);
    logic [N_SRC*SAXIS_DATA_WIDTH-1:0] S_AXIS_SRC_tdata;
    logic [N_SRC-1:0]                  S_AXIS_SRC_tvalid;
    logic [MAXIS_DATA_WIDTH-1:0]       M_AXIS_tdata;
    logic                              M_AXIS_tvalid;
    logic [SAXIS_DATA_WIDTH-1:0]       M_AXIS_ABS_tdata;
    logic                              M_AXIS_ABS_tvalid;

    // master drives the sources and observes the results; slave is the selector itself
    modport master (
        output S_AXIS_SRC_tdata, S_AXIS_SRC_tvalid,
        input  M_AXIS_tdata, M_AXIS_tvalid, M_AXIS_ABS_tdata, M_AXIS_ABS_tvalid
    );
    modport slave (
        input  S_AXIS_SRC_tdata, S_AXIS_SRC_tvalid,
        output M_AXIS_tdata, M_AXIS_tvalid, M_AXIS_ABS_tdata, M_AXIS_ABS_tvalid
    );
endinterface

// File: rtl/axis_ctrlsrc_select_mc.sv
// rtl/axis_ctrlsrc_select_mc.sv - N-source control selector with shift/offset, |x|+floor and bumpless hold
// Define AXIS_CTRLSRC_SAT_EN to saturate the offset sum instead of wrapping it.
module axis_ctrlsrc_select_mc #(
    parameter int SAXIS_DATA_WIDTH = 32,
    parameter int MAXIS_DATA_WIDTH = 32,
    parameter int N_SRC            = 4,
    parameter int SEL_WIDTH        = 2,
    parameter int SETTLE_WIDTH     = 16
) (
    input  logic                        a_clk,
    input  logic                        a_rst,
    axis_ctrlsrc_select_mc_if.slave     axis,
    input  logic [SEL_WIDTH-1:0]        selection,
    input  logic [4:0]                  shift,
    input  logic [SAXIS_DATA_WIDTH-1:0] signal_offset,
    input  logic [15:0]                 abs_floor,
    input  logic [SETTLE_WIDTH-1:0]     settle_cycles,
    output logic                        hold_active,
    output logic [SEL_WIDTH-1:0]        active_sel
);
    localparam int W = SAXIS_DATA_WIDTH;
    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic {ST_RUN, ST_HOLD} state_t;

    state_t                  state_q, state_d;
    logic [SETTLE_WIDTH-1:0] cnt_q, cnt_d;
    logic [SEL_WIDTH-1:0]    active_sel_q, active_sel_d;
    logic                    sel_change;
    logic                    s3_en;

    logic signed [W-1:0] d1_q, d1_d, o1_q, o1_d;
    logic signed [W-1:0] x2_q, x2_d, x3_q, x3_d;
    logic [W-1:0]        abs3_q, abs3_d;
    logic                v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;

    logic signed [W-1:0] src_sel;
    logic                v_sel;
    logic [W:0]          sum2;
    logic [W-1:0]        mag;
    logic [W:0]          abs_sum;

    assign sel_change = (int'(selection) < N_SRC) && (selection != active_sel_q);

    always_ff @(posedge a_clk) begin
        if (a_rst) begin
            state_q      <= ST_RUN;
            cnt_q        <= '0;
            active_sel_q <= '0;
            d1_q <= '0; o1_q <= '0; x2_q <= '0; x3_q <= '0; abs3_q <= '0;
            v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            active_sel_q <= active_sel_d;
            d1_q <= d1_d; o1_q <= o1_d; x2_q <= x2_d; x3_q <= x3_d; abs3_q <= abs3_d;
            v1_q <= v1_d; v2_q <= v2_d; v3_q <= v3_d;
        end
    end

    // A switch (in RUN or HOLD) always restarts the settle window from settle_cycles.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        active_sel_d = active_sel_q;
        if (sel_change) begin
            active_sel_d = selection;
            cnt_d        = settle_cycles;
            state_d      = (settle_cycles == '0) ? ST_RUN : ST_HOLD;
        end else if (state_q == ST_HOLD) begin
            if (cnt_q <= SETTLE_WIDTH'(1)) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - SETTLE_WIDTH'(1);
            end
        end
    end

    // S3 captures in every RUN cycle, including the last HOLD cycle that hands back to RUN.
    always_comb begin
        hold_active = (state_q == ST_HOLD);
        s3_en       = (state_q == ST_RUN) || (state_d == ST_RUN);
    end

    always_comb begin
        src_sel = '0;
        v_sel   = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            if (int'(active_sel_q) == k) begin
                src_sel = axis.S_AXIS_SRC_tdata[k*W +: W];
                v_sel   = axis.S_AXIS_SRC_tvalid[k];
            end
        end
        d1_d = src_sel >>> shift;
        o1_d = $signed(signal_offset) >>> shift;
        v1_d = v_sel;

        sum2 = {d1_q[W-1], d1_q} + {o1_q[W-1], o1_q};
`ifdef AXIS_CTRLSRC_SAT_EN
        if (sum2[W] ^ sum2[W-1]) begin
            x2_d = sum2[W] ? MIN_NEG : MAX_POS;
        end else begin
            x2_d = sum2[W-1:0];
        end
`else
        x2_d = sum2[W-1:0];
`endif
        v2_d = v1_q;

        if (x2_q == MIN_NEG) begin
            mag = MAX_POS;
        end else if (x2_q[W-1]) begin
            mag = -x2_q;
        end else begin
            mag = x2_q;
        end
        abs_sum = {1'b0, mag} + (W+1)'(abs_floor);
        x3_d    = s3_en ? x2_q : x3_q;
        abs3_d  = s3_en ? (abs_sum[W] ? '1 : abs_sum[W-1:0]) : abs3_q;
        v3_d    = v2_q;
    end

    assign axis.M_AXIS_tdata      = MAXIS_DATA_WIDTH'(x3_q);
    assign axis.M_AXIS_tvalid     = v3_q;
    assign axis.M_AXIS_ABS_tdata  = abs3_q;
    assign axis.M_AXIS_ABS_tvalid = v3_q;
    assign active_sel             = active_sel_q;
endmodule

// File: tb/tb_axis_ctrlsrc_select_mc.sv
// tb/tb_axis_ctrlsrc_select_mc.sv - scoreboard bench for axis_ctrlsrc_select_mc
`timescale 1ns/1ps
module tb_axis_ctrlsrc_select_mc;
    localparam int W   = 32;
    localparam int MW  = 32;
    localparam int NS  = 4;
    localparam int SW  = 3;
    localparam int STW = 16;
`ifdef AXIS_CTRLSRC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic a_clk = 1'b0;
    logic a_rst;
    always #5 a_clk = ~a_clk;

    axis_ctrlsrc_select_mc_if #(.SAXIS_DATA_WIDTH(W), .MAXIS_DATA_WIDTH(MW), .N_SRC(NS)) axis ();

    logic [SW-1:0]  selection;
    logic [4:0]     shift;
    logic [W-1:0]   signal_offset;
    logic [15:0]    abs_floor;
    logic [STW-1:0] settle_cycles;
    logic           hold_active;
    logic [SW-1:0]  active_sel;

    axis_ctrlsrc_select_mc #(
        .SAXIS_DATA_WIDTH(W), .MAXIS_DATA_WIDTH(MW), .N_SRC(NS),
        .SEL_WIDTH(SW), .SETTLE_WIDTH(STW)
    ) dut (
        .a_clk(a_clk), .a_rst(a_rst), .axis(axis),
        .selection(selection), .shift(shift), .signal_offset(signal_offset),
        .abs_floor(abs_floor), .settle_cycles(settle_cycles),
        .hold_active(hold_active), .active_sel(active_sel)
    );

    logic [W-1:0]  src [NS];
    logic [NS-1:0] vld;
    always_comb begin
        axis.S_AXIS_SRC_tdata = '0;
        for (int k = 0; k < NS; k++) axis.S_AXIS_SRC_tdata[k*W +: W] = src[k];
        axis.S_AXIS_SRC_tvalid = vld;
    end

    int checks = 0;
    int errors = 0;
    logic [MW-1:0] exp_t_q [$];
    logic [W-1:0]  exp_a_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge a_clk);
        #1;
    endtask

    // Monitor: every presented output is matched against the next scoreboard entry.
    always @(negedge a_clk) begin
        logic [MW-1:0] et;
        logic [W-1:0]  ea;
        if (!a_rst && axis.M_AXIS_tvalid) begin
            if (exp_t_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got 0x%0h expected none", axis.M_AXIS_tdata);
            end else begin
                et = exp_t_q.pop_front();
                ea = exp_a_q.pop_front();
                chk("m_tdata", axis.M_AXIS_tdata, et);
                chk("abs_tdata", axis.M_AXIS_ABS_tdata, ea);
                chk("abs_tvalid", axis.M_AXIS_ABS_tvalid, 1);
            end
        end
    end

    task automatic send(input int ch, input logic [W-1:0] data, input logic [MW-1:0] et,
                        input logic [W-1:0] ea, input string name);
        src[ch] = data;
        vld     = '0;
        vld[ch] = 1'b1;
        exp_t_q.push_back(et);
        exp_a_q.push_back(ea);
        step();
        vld = '0;
        for (int k = 0; k < 3; k++) begin
            chk({name, "_tvalid_lat"}, axis.M_AXIS_tvalid, (k == 2));
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        a_rst = 1'b1;
        selection = '0; shift = '0; signal_offset = '0; abs_floor = '0; settle_cycles = '0;
        vld = '0;
        for (int k = 0; k < NS; k++) src[k] = '0;
        repeat (3) step();
        chk("rst_tdata", axis.M_AXIS_tdata, 0);
        chk("rst_tvalid", axis.M_AXIS_tvalid, 0);
        chk("rst_abs", axis.M_AXIS_ABS_tdata, 0);
        chk("rst_hold", hold_active, 0);
        chk("rst_active_sel", active_sel, 0);
        a_rst = 1'b0;
        step();

        shift = 5'd8; signal_offset = 32'hFFFF_FE00; abs_floor = 16'd1;
        send(0, 32'h0000_1000, 32'h0000_000E, 32'h0000_000F, "t1");
        shift = 5'd0; signal_offset = '0; abs_floor = 16'd1;
        send(0, 32'hFFFF_FD00, 32'hFFFF_FD00, 32'h0000_0301, "t2");
        shift = 5'd31; signal_offset = 32'h1234_5678; abs_floor = 16'h0010;
        send(0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0011, "shift31");
        shift = 5'd4; signal_offset = 32'h0000_0050; abs_floor = 16'h0000;
        send(0, 32'h0000_0123, 32'h0000_0017, 32'h0000_0017, "shift4");

        // Switch 0 -> 2 with a 5-cycle settle window, sources streaming continuously.
        shift = '0; signal_offset = '0; abs_floor = '0; settle_cycles = 16'd5;
        src[0] = 32'h100; src[1] = 32'h333; src[2] = 32'h500; src[3] = 32'h444;
        vld = '1;
        for (int i = 0; i < 12; i++) begin
            if (i == 4) selection = 3'd2;
            exp_t_q.push_back((i <= 6) ? 32'h100 : 32'h500);
            exp_a_q.push_back((i <= 6) ? 32'h100 : 32'h500);
            step();
            chk("t3_hold", hold_active, (i >= 4 && i <= 8));
            chk("t3_active_sel", active_sel, (i >= 4) ? 2 : 0);
        end

        // Switch 2 -> 0, then 0 -> 1 at count 2 reloads; selection 7 is ignored.
        for (int j = 0; j < 12; j++) begin
            if (j == 0) selection = 3'd0;
            if (j == 4) selection = 3'd1;
            if (j == 6) selection = 3'd7;
            exp_t_q.push_back((j <= 6) ? 32'h500 : 32'h333);
            exp_a_q.push_back((j <= 6) ? 32'h500 : 32'h333);
            step();
            chk("t4_hold", hold_active, (j <= 8));
            chk("t4_active_sel", active_sel, (j < 4) ? 0 : 1);
        end

        vld = '0; settle_cycles = '0; selection = 3'd0;
        repeat (4) step();
        chk("t5_active_sel", active_sel, 0);
        chk("t5_hold", hold_active, 0);

        signal_offset = 32'h7FFF_FFFF;
        send(0, 32'h7FFF_FFFF, SAT ? 32'h7FFF_FFFF : 32'hFFFF_FFFE,
             SAT ? 32'h7FFF_FFFF : 32'h0000_0002, "t5_pos_ovf");
        signal_offset = 32'h8000_0000;
        send(0, 32'h8000_0000, SAT ? 32'h8000_0000 : 32'h0000_0000,
             SAT ? 32'h7FFF_FFFF : 32'h0000_0000, "t5_neg_ovf");
        signal_offset = '0; abs_floor = 16'hFFFF;
        send(0, 32'h8000_0000, 32'h8000_0000, 32'h8000_FFFE, "t6_minneg");

        // Reset in the middle of a hold window.
        settle_cycles = 16'd10; selection = 3'd3;
        step();
        step();
        chk("t6_pre_hold", hold_active, 1);
        chk("t6_pre_tdata", axis.M_AXIS_tdata, 32'h8000_0000);
        chk("t6_pre_active_sel", active_sel, 3);
        a_rst = 1'b1;
        selection = 3'd0;
        step();
        chk("t6_rst_hold", hold_active, 0);
        chk("t6_rst_tdata", axis.M_AXIS_tdata, 0);
        chk("t6_rst_abs", axis.M_AXIS_ABS_tdata, 0);
        chk("t6_rst_tvalid", axis.M_AXIS_tvalid, 0);
        chk("t6_rst_active_sel", active_sel, 0);
        a_rst = 1'b0;
        repeat (2) step();
        chk("t6_post_hold", hold_active, 0);

        repeat (4) step();
        chk("sb_empty", exp_t_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
